// File: rtl/sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sweep_ctrl
//
// Purpose:
//   Sequencer that sits upstream of a loadable up/down counter. It drives the
//   counter's load/udi/d_in so that the count sweeps as a triangle wave
//   between two bounds (lo, hi) for a programmed number of full periods, then
//   holds. The counter output is fed back on q_in. Each reversal is decided
//   one cycle ahead, so the count never overshoots a bound.
//
// Parameters:
//   N          counter width (must match the driven counter)
//   PW         width of the period count
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   synchronous active-low reset
//   start       in   one-cycle request to begin a sweep
//   stop        in   level-sampled abort request
//   lo, hi      in   sweep bounds, captured when a start is accepted
//   n_periods   in   full up+down periods to run, 0 = run until stop
//   q_in        in   counter q_out feedback
//   load        out  counter load enable
//   udi         out  counter direction (1 = up, 0 = down)
//   d_out       out  counter parallel-load data
//   busy        out  high while a sweep is in progress
//   done        out  one-cycle pulse when the programmed periods complete
//   err         out  one-cycle pulse when a start is rejected (lo >= hi)
//   period_cnt  out  periods completed in the current sweep
// ---------------------------------------------------------------------------
module sweep_ctrl #(
    parameter int N  = 4,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [N-1:0]  lo,
    input  logic [N-1:0]  hi,
    input  logic [PW-1:0] n_periods,
    input  logic [N-1:0]  q_in,
    output logic          load,
    output logic          udi,
    output logic [N-1:0]  d_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] period_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_e;

    localparam logic [N-1:0]  ONE_N  = 1;
    localparam logic [PW-1:0] ONE_PW = 1;
    localparam logic [PW-1:0] ZERO_PW = '0;

    state_e        state_q, state_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [PW-1:0] np_q, np_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          load_q, load_d;
    logic          udi_q, udi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [N-1:0]  hiMinusOne;
    logic [N-1:0]  loPlusOne;
    logic [PW-1:0] pcntInc;

    // Turn-around thresholds. Because lo < hi is guaranteed for any accepted
    // sweep, neither of these can wrap while they are being used.
    assign hiMinusOne = hi_q - ONE_N;
    assign loPlusOne  = lo_q + ONE_N;
    assign pcntInc    = pcnt_q + ONE_PW;

    // Next-state logic. Reversals are taken when the count is one step short
    // of a bound: the counter still moves on that same edge, so the bound
    // value itself shows up for exactly one cycle. Stop wins over everything
    // else, both in IDLE (over start) and while busy (over period completion).
    // The registered outputs are derived from the state being entered, so
    // they line up with state_q in the following cycle.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        np_d    = np_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    if (lo < hi) begin
                        lo_d    = lo;
                        hi_d    = hi;
                        np_d    = n_periods;
                        pcnt_d  = ZERO_PW;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = UP;
                end
            end
            UP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (q_in == hiMinusOne) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (q_in == loPlusOne) begin
                    pcnt_d = pcntInc;
                    if ((np_q != ZERO_PW) && (pcntInc == np_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = UP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_d = (state_d == IDLE) || (state_d == LOAD);
        udi_d  = (state_d == UP);
        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset puts the counter into hold (load=1
    // with d_out following q_in) so the count is frozen while in reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            np_q    <= '0;
            pcnt_q  <= '0;
            load_q  <= 1'b1;
            udi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            np_q    <= np_d;
            pcnt_q  <= pcnt_d;
            load_q  <= load_d;
            udi_q   <= udi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // In LOAD the counter takes the lower bound; in every other state it
    // reloads its own value, which is how it is held still while idle.
    assign d_out      = (state_q == LOAD) ? lo_q : q_in;

    assign load       = load_q;
    assign udi        = udi_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign period_cnt = pcnt_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sweep_ctrl
//
// Purpose:
//   Self-checking bench for sweep_ctrl. A small behavioural model of the
//   loadable up/down counter closes the q_out -> q_in loop, and directed
//   sweeps are compared against hand-written count sequences.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_sweep_ctrl;

    localparam int N  = 4;
    localparam int PW = 8;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic [N-1:0]  lo;
    logic [N-1:0]  hi;
    logic [PW-1:0] n_periods;
    logic [N-1:0]  cnt;
    logic          load;
    logic          udi;
    logic [N-1:0]  d_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] period_cnt;

    int checkCount = 0;
    int failCount  = 0;

    sweep_ctrl #(.N(N), .PW(PW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .lo         (lo),
        .hi         (hi),
        .n_periods  (n_periods),
        .q_in       (cnt),
        .load       (load),
        .udi        (udi),
        .d_out      (d_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .period_cnt (period_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural loadable up/down counter driven by the sequencer.
    initial cnt = '0;
    always @(posedge clk) begin
        if (load) begin
            cnt <= d_out;
        end else if (udi) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present bounds and period count and pulse start for one cycle.
    task automatic applyStimulus(input logic [N-1:0] l, input logic [N-1:0] h,
                                 input logic [PW-1:0] np);
        lo        = l;
        hi        = h;
        n_periods = np;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Directed scenarios run back to back.
    initial begin
        logic [N-1:0] hold;
        logic         found;
        int seq2 [13] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
        int seq3 [7]  = '{5, 6, 5, 6, 5, 6, 5};
        int seq6 [5]  = '{4, 3, 2, 3, 4};

        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        lo        = '0;
        hi        = '0;
        n_periods = '0;

        $display("[TB] reset behaviour");
        step();
        step();
        checkOutput("rst_load", load, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pcnt", period_cnt, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_udi", udi, 0);
        hold = cnt;
        step();
        checkOutput("rst_hold", cnt, hold);
        reset_n = 1'b1;
        step();
        checkOutput("idle_hold", cnt, hold);

        $display("[TB] sweep 3..6 for 2 periods");
        applyStimulus(4'd3, 4'd6, 8'd2);
        checkOutput("t2_load", load, 1);
        checkOutput("t2_busy", busy, 1);
        checkOutput("t2_dout", d_out, 3);
        for (int i = 0; i < 13; i++) begin
            step();
            checkOutput($sformatf("t2_q%0d", i), cnt, seq2[i]);
            checkOutput($sformatf("t2_done%0d", i), done, (i == 12) ? 1 : 0);
        end
        checkOutput("t2_pcnt", period_cnt, 2);
        checkOutput("t2_busy_end", busy, 0);
        step();
        checkOutput("t2_held", cnt, 3);
        checkOutput("t2_done_clr", done, 0);

        $display("[TB] sweep 5..6 for 3 periods");
        applyStimulus(4'd5, 4'd6, 8'd3);
        checkOutput("t3_pcnt_clr", period_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput($sformatf("t3_q%0d", i), cnt, seq3[i]);
            checkOutput($sformatf("t3_done%0d", i), done, (i == 6) ? 1 : 0);
        end
        checkOutput("t3_pcnt", period_cnt, 3);
        step();
        checkOutput("t3_held", cnt, 5);

        $display("[TB] rejected start lo>=hi");
        hold = cnt;
        applyStimulus(4'd9, 4'd9, 8'd1);
        checkOutput("t4_err", err, 1);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_q", cnt, hold);
        step();
        checkOutput("t4_err_clr", err, 0);
        checkOutput("t4_q_held", cnt, hold);

        $display("[TB] stop outranks start in idle");
        stop = 1'b1;
        applyStimulus(4'd1, 4'd4, 8'd1);
        stop = 1'b0;
        checkOutput("pri_busy", busy, 0);
        checkOutput("pri_err", err, 0);

        $display("[TB] endless sweep with stop");
        applyStimulus(4'd0, 4'd15, 8'd0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cnt == 4'd10 && udi == 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t5_reach10", found, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checkOutput("t5_q", cnt, 11);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        step();
        checkOutput("t5_held", cnt, 11);

        $display("[TB] start ignored while busy, then reset mid-sweep");
        applyStimulus(4'd2, 4'd5, 8'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy && !udi && !load) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t6_reach_down", found, 1);
        checkOutput("t6_top", cnt, 5);
        lo    = 4'd0;
        hi    = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("t6_err", err, 0);
        checkOutput("t6_busy", busy, 1);
        checkOutput($sformatf("t6_q%0d", 0), cnt, seq6[0]);
        for (int i = 1; i < 5; i++) begin
            step();
            checkOutput($sformatf("t6_q%0d", i), cnt, seq6[i]);
        end
        checkOutput("t6_udi", udi, 1);
        checkOutput("t6_pcnt", period_cnt, 1);
        reset_n = 1'b0;
        step();
        checkOutput("t6_rst_load", load, 1);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_udi", udi, 0);
        checkOutput("t6_rst_pcnt", period_cnt, 0);
        checkOutput("t6_rst_q", cnt, 5);
        step();
        checkOutput("t6_rst_hold", cnt, 5);
        reset_n = 1'b1;
        step();
        checkOutput("t6_idle_hold", cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
